// File: rtl/sort4_sequencer_pkg.sv
// Shared constants for the sort4 sequencer: element width and FSM state encoding.
package sort4_sequencer_pkg;

    localparam int ELEM_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/sort4_sequencer_if.sv
// Request/result bundle for sort4_sequencer. Handshake: start is taken only while busy=0;
// done is a one-cycle pulse, and out_data/swap_count stay stable from done until the next done.
interface sort4_sequencer_if
    import sort4_sequencer_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 3
);

    logic                  start;
    logic [ELEM_W*N-1:0]   in_data;
    logic                  busy;
    logic                  done;
    logic [ELEM_W*N-1:0]   out_data;
    logic [CNT_W-1:0]      swap_count;
    state_e                dbg_state;

    modport master (
        output start, in_data,
        input  busy, done, out_data, swap_count, dbg_state
    );

    modport slave (
        input  start, in_data,
        output busy, done, out_data, swap_count, dbg_state
    );

endinterface

// File: rtl/magnitude_comparator.sv
// Purely combinational unsigned magnitude comparator; exactly one output is high.
module magnitude_comparator
    import sort4_sequencer_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              a_gt_b,
    output logic              a_eq_b,
    output logic              a_lt_b
);

    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign a_lt_b = (a < b);

endmodule

// File: rtl/sort4_sequencer.sv
// Bubble-sort controller: one shared comparator, one compare per cycle, early exit on a clean pass.
module sort4_sequencer
    import sort4_sequencer_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    sort4_sequencer_if.slave   bus
);

    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

    state_e                state_q, state_d;
    logic [ELEM_W-1:0]     r_q [N];
    logic [ELEM_W-1:0]     r_d [N];
    logic [IDX_W-1:0]      idx_q, idx_d, last_q, last_d, idx_nxt;
    logic                  swapped_q, swapped_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      swap_count_q, swap_count_d;
    logic [ELEM_W*N-1:0]   out_data_q, out_data_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [ELEM_W-1:0]     cmp_a, cmp_b;
    logic                  cmp_gt, cmp_eq, cmp_lt, swap_now;

    assign idx_nxt = idx_q + IDX_W'(1);
    assign cmp_a   = r_q[idx_q];
    assign cmp_b   = r_q[idx_nxt];

    magnitude_comparator u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (cmp_gt),
        .a_eq_b (cmp_eq),
        .a_lt_b (cmp_lt)
    );

    // Equal or smaller keeps order, which is what makes the sort stable.
    assign swap_now = cmp_gt & ~(cmp_eq | cmp_lt);

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        idx_d        = idx_q;
        last_d       = last_q;
        swapped_d    = swapped_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        swap_count_d = swap_count_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N; i++) begin
                        r_d[i] = bus.in_data[ELEM_W*i +: ELEM_W];
                    end
                    idx_d     = '0;
                    last_d    = IDX_W'(N - 2);
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (swap_now) begin
                    r_d[idx_q]   = cmp_b;
                    r_d[idx_nxt] = cmp_a;
                    swapped_d    = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                end
                if (idx_q != last_q) begin
                    idx_d = idx_nxt;
                end else if (last_q == '0 || !(swapped_q || swap_now)) begin
                    state_d = DONE;
                end else begin
                    last_d    = last_q - IDX_W'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture the result using this cycle's post-swap values so DONE presents it.
        if (state_q == COMPARE && state_d == DONE) begin
            for (int i = 0; i < N; i++) begin
                out_data_d[ELEM_W*i +: ELEM_W] = r_d[i];
            end
            swap_count_d = cnt_d;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < N; i++) begin
                r_q[i] <= '0;
            end
            idx_q        <= '0;
            last_q       <= IDX_W'(N - 2);
            swapped_q    <= 1'b0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            swap_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            swapped_q    <= swapped_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            swap_count_q <= swap_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.out_data   = out_data_q;
    assign bus.swap_count = swap_count_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sort4_sequencer.sv
// Scoreboard bench for sort4_sequencer: directed cases, randomized vectors, busy-start and mid-sort reset.
module tb_sort4_sequencer;
    import sort4_sequencer_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 3;
    localparam int DW    = ELEM_W * N;
    localparam int W     = 16 + DW + CNT_W;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sort4_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    sort4_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard: {due_edge[15:0], out_data, swap_count}
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bubble sort result from first principles. Swaps = inversion count;
    // passes that swap = largest leftward travel of any element, plus one clean pass if room remains.
    function automatic void model(input logic [DW-1:0] d, output logic [DW-1:0] sorted,
                                  output int swaps, output int lat);
        int v[N];
        int q[$];
        int disp, maxd, passes, cmps;
        for (int i = 0; i < N; i++) v[i] = int'(d[ELEM_W*i +: ELEM_W]);
        swaps = 0;
        maxd  = 0;
        for (int i = 0; i < N; i++) begin
            disp = 0;
            for (int j = 0; j < i; j++) if (v[j] > v[i]) disp++;
            swaps += disp;
            if (disp > maxd) maxd = disp;
        end
        passes = (maxd + 1 < N - 1) ? maxd + 1 : N - 1;
        cmps = 0;
        for (int p = 1; p <= passes; p++) cmps += N - p;
        lat = cmps + 1;
        for (int i = 0; i < N; i++) q.push_back(v[i]);
        q.sort();
        sorted = '0;
        for (int i = 0; i < N; i++) sorted[ELEM_W*i +: ELEM_W] = ELEM_W'(q[i]);
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("done_edge", 32'(edge_cnt + 1), 32'(e[W-1 -: 16]));
                check("out_data", 32'(bus.out_data), 32'(e[DW+CNT_W-1 -: DW]));
                check("swap_count", 32'(bus.swap_count), 32'(e[CNT_W-1:0]));
            end
        end
    end

    // driver tasks
    task automatic wait_idle();
        int i;
        @(negedge clk);
        for (i = 0; i < 50 && bus.busy; i++) @(negedge clk);
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [DW-1:0] data);
        logic [DW-1:0] sorted;
        int swaps, lat;
        wait_idle();
        bus.start   = 1'b1;
        bus.in_data = data;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.in_data = DW'($urandom);
        model(data, sorted, swaps, lat);
        exp_q.push_back({16'(edge_cnt + lat), sorted, CNT_W'(swaps)});
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_sort(input logic [DW-1:0] data);
        issue(data);
        wait_drain();
    endtask

    logic [DW-1:0] directed [6];

    initial begin
        logic [DW-1:0] v;
        directed[0] = 16'h0213;
        directed[1] = 16'h3210;
        directed[2] = 16'h05AF;
        directed[3] = 16'h7777;
        directed[4] = 16'h0F0F;
        directed[5] = 16'hFA50;

        bus.start   = 1'b0;
        bus.in_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out", 32'(bus.out_data), 32'd0);
        check("rst_cnt", 32'(bus.swap_count), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_sort(directed[i]);

        // Second start with new data while busy must be ignored.
        issue(16'h05AF);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.in_data = 16'h1234;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("no_extra_done", 32'(exp_q.size()), 32'd0);

        // Reset sampled at edge k+3 of a reverse-order sort.
        issue(16'h05AF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_out", 32'(bus.out_data), 32'd0);
        check("midrst_cnt", 32'(bus.swap_count), 32'd0);
        check("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_sort(16'h05AF);

        // Randomized vectors, half of them with a narrow value range to force duplicates.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                v = DW'($urandom);
            end else begin
                for (int j = 0; j < N; j++) v[ELEM_W*j +: ELEM_W] = ELEM_W'($urandom_range(0, 3));
            end
            run_sort(v);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
